stack_arbiter: RTL and testbench

//  Shares one stack instance (WIDTH x 2**ADDR_WIDTH LIFO) between two requester ports.

---
 rtl/stack_arb_pkg.sv | 11 +
 rtl/stack_arbiter_rr_arb2.sv | 14 +
 rtl/stack_arbiter.sv | 120 ++++++++++++
 tb/tb_stack_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// Shared encodings for the two-port stack arbiter: FSM states and op codes.
package stack_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational; the caller owns the last-served register.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_id,
    output logic gnt_valid
);

    // On a tie the port that was not served last wins; otherwise the sole requester.
    assign gnt_id    = (req0 && req1) ? ~last : req1;
    assign gnt_valid = req0 | req1;

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO between two requesters: IDLE -> EXEC (one strobe) -> ACK, illegal ops get an error ack.
// Optional rejected-op counter on err_cnt when STACK_ARB_STATS_EN is defined.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 op0,
    input  logic                 op1,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic [WIDTH-1:0]     wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic [WIDTH-1:0]     rdata,
    output logic                 busy,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [WIDTH-1:0]     stk_wdata,
    input  logic [WIDTH-1:0]     stk_rdata,
    input  logic                 stk_full,
    input  logic                 stk_empty
`ifdef STACK_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] err_cnt
`endif
);

    logic [1:0]       r_state;
    logic             r_gid;
    logic             r_op;
    logic [WIDTH-1:0] r_wdata;
    logic             r_last;
    logic             r_err;
    logic [WIDTH-1:0] r_rdata;

    logic             w_gnt_id;
    logic             w_gnt_vld;
    logic             w_in_exec;
    logic             w_illegal;

    rr_arb2 u_rr (
        .req0      (req0),
        .req1      (req1),
        .last      (r_last),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_vld)
    );

    assign w_in_exec = (r_state == ST_EXEC);
    assign w_illegal = (r_op == OP_PUSH) ? stk_full : stk_empty;

    // Strobes are decoded from state so an async reset kills them within the same cycle.
    assign stk_push  = w_in_exec && !w_illegal && (r_op == OP_PUSH);
    assign stk_pop   = w_in_exec && !w_illegal && (r_op == OP_POP);
    assign stk_wdata = r_wdata;

    assign ack0  = (r_state == ST_ACK) && !r_gid;
    assign ack1  = (r_state == ST_ACK) &&  r_gid;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign busy  = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_gid   <= 1'b0;
            r_op    <= OP_POP;
            r_wdata <= '0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gid   <= w_gnt_id;
                        r_op    <= w_gnt_id ? op1 : op0;
                        r_wdata <= w_gnt_id ? wdata1 : wdata0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_err   <= w_illegal;
                    // Top-of-stack is captured before the pop strobe takes effect.
                    r_rdata <= (!w_illegal && (r_op == OP_POP)) ? stk_rdata : '0;
                    r_last  <= r_gid;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STACK_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_in_exec && w_illegal && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural LIFO environment, transaction-level reference model, directed + random stimulus.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [1:0] wdata0 = 2'b0, wdata1 = 2'b0;
    logic       ack0, ack1, err, busy, stk_push, stk_pop;
    logic [1:0] rdata, stk_wdata, stk_rdata;
    logic       stk_full, stk_empty;
`ifdef STACK_ARB_STATS_EN
    logic [7:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.WIDTH(2), .ADDR_WIDTH(2), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_rdata (stk_rdata),
        .stk_full  (stk_full),
        .stk_empty (stk_empty)
`ifdef STACK_ARB_STATS_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: a depth-4 stack driven by the DUT strobes, cleared only by clr_stk.
    logic       clr_stk = 1'b0;
    logic [1:0] s_mem [4];
    int         s_cnt = 0;
    int         n_push = 0, n_pop = 0;

    assign stk_full  = (s_cnt == 4);
    assign stk_empty = (s_cnt == 0);
    assign stk_rdata = (s_cnt > 0) ? s_mem[s_cnt-1] : 2'b00;

    always @(posedge clk) begin
        if (clr_stk) begin
            s_cnt <= 0;
        end else if (stk_push && s_cnt < 4) begin
            s_mem[s_cnt] <= stk_wdata;
            s_cnt <= s_cnt + 1;
        end else if (stk_pop && s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
        end
        if (stk_push) n_push <= n_push + 1;
        if (stk_pop)  n_pop  <= n_pop + 1;
    end

    // Reference model: m_ph counts cycles into a transaction (0 = idle, 1 = strobe cycle, 2 = ack cycle).
    int         m_ph = 0;
    logic       m_gid = 1'b0, m_op = 1'b0, m_last = 1'b1, m_err = 1'b0;
    logic [1:0] m_wd = 2'b0, m_rdata = 2'b0;
    int         m_errcnt = 0;
    logic [1:0] ref_q [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = 0; m_last = 1'b1; m_err = 1'b0; m_rdata = 2'b0; m_errcnt = 0;
            if (clr_stk) ref_q.delete();
        end else if (m_ph == 0) begin
            if (req0 || req1) begin
                m_gid = (req0 && req1) ? !m_last : req1;
                m_op  = m_gid ? op1 : op0;
                m_wd  = m_gid ? wdata1 : wdata0;
                m_ph  = 1;
            end
        end else if (m_ph == 1) begin
            m_err   = m_op ? (ref_q.size() >= 4) : (ref_q.size() == 0);
            m_rdata = 2'b0;
            if (!m_err) begin
                if (m_op) ref_q.push_back(m_wd);
                else      m_rdata = ref_q.pop_back();
            end else if (m_errcnt < 255) begin
                m_errcnt++;
            end
            m_last = m_gid;
            m_ph   = 2;
        end else begin
            m_ph = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            automatic logic e_push = (m_ph == 1) &&  m_op && (ref_q.size() < 4);
            automatic logic e_pop  = (m_ph == 1) && !m_op && (ref_q.size() > 0);
            chk("stk_push", stk_push, e_push);
            chk("stk_pop",  stk_pop,  e_pop);
            chk("busy",     busy,     m_ph != 0);
            chk("ack0",     ack0,     (m_ph == 2) && !m_gid);
            chk("ack1",     ack1,     (m_ph == 2) &&  m_gid);
            chk("err",      err,      m_err);
            chk("rdata",    rdata,    m_rdata);
            chk("depth",    s_cnt,    ref_q.size());
            if (e_push) chk("stk_wdata", stk_wdata, m_wd);
`ifdef STACK_ARB_STATS_EN
            chk("err_cnt",  err_cnt,  m_errcnt);
`endif
        end
    end

    task automatic do_reset(input logic clr);
        @(negedge clk);
        clr_stk = clr;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        clr_stk = 1'b0;
        chk("reset_outs", {ack0, ack1, err, rdata, busy, stk_push, stk_pop, stk_wdata}, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One request on a port; req is dropped and op/wdata scrambled right after grant.
    task automatic do_op(input int port, input logic op, input logic [1:0] wd,
                         output logic e, output logic [1:0] rd, output int lat);
        logic got;
        got = 1'b0; e = 1'b0; rd = 2'b0; lat = 0;
        @(posedge clk); #1;
        if (port == 0) begin req0 = 1'b1; op0 = op; wdata0 = wd; end
        else           begin req1 = 1'b1; op1 = op; wdata1 = wd; end
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if ((port == 0) ? ack0 : ack1) begin
                got = 1'b1; e = err; rd = rdata;
            end
            if (lat == 2) begin
                if (port == 0) begin req0 = 1'b0; op0 = ~op; wdata0 = ~wd; end
                else           begin req1 = 1'b0; op1 = ~op; wdata1 = ~wd; end
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    logic       e;
    logic [1:0] rd;
    int         lat, p0, q0;
    int         order [4];

    initial begin
        do_reset(1'b1);

        // 1: first push from reset
        p0 = n_push;
        do_op(0, 1'b1, 2'b10, e, rd, lat);
        chk("t1_lat", lat, 3);
        chk("t1_err", e, 0);
        chk("t1_strobes", n_push - p0, 1);

        // 2: push 1,2,3 then pops return 3 then 2
        do_reset(1'b1);
        for (int i = 1; i <= 3; i++) do_op(0, 1'b1, i[1:0], e, rd, lat);
        do_op(1, 1'b0, 2'b00, e, rd, lat);
        chk("t2_pop1_rdata", rd, 3);
        chk("t2_pop1_err", e, 0);
        do_op(1, 1'b0, 2'b00, e, rd, lat);
        chk("t2_pop2_rdata", rd, 2);

        // 3: pop on empty
        do_reset(1'b1);
        q0 = n_pop;
        do_op(1, 1'b0, 2'b00, e, rd, lat);
        chk("t3_err", e, 1);
        chk("t3_rdata", rd, 0);
        chk("t3_no_strobe", n_pop - q0, 0);
`ifdef STACK_ARB_STATS_EN
        chk("t3_err_cnt", err_cnt, 1);
`endif

        // 4: overflow push is rejected and contents survive
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) do_op(0, 1'b1, i[1:0], e, rd, lat);
        p0 = n_push;
        do_op(1, 1'b1, 2'b01, e, rd, lat);
        chk("t4_err", e, 1);
        chk("t4_no_strobe", n_push - p0, 0);
        chk("t4_full", stk_full, 1);
        for (int i = 3; i >= 0; i--) begin
            do_op(0, 1'b0, 2'b00, e, rd, lat);
            chk("t4_pop_order", rd, i);
        end

        // 5: both ports held pushing -> grants alternate starting at 0
        do_reset(1'b1);
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 1'b1; wdata0 = 2'b01;
        req1 = 1'b1; op1 = 1'b1; wdata1 = 2'b10;
        begin
            int n = 0;
            for (int c = 0; c < 40 && n < 4; c++) begin
                @(negedge clk);
                if (ack0) begin order[n] = 0; n++; end
                else if (ack1) begin order[n] = 1; n++; end
            end
            chk("t5_ack_count", n, 4);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) chk("t5_grant_order", order[i], i % 2);

        // 6: reset during the strobe cycle aborts the op
        do_reset(1'b1);
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 1'b1; wdata0 = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("t6_exec_push", stk_push, 1);
        #1;
        reset_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("t6_async_clear", {ack0, ack1, err, rdata, busy, stk_push, stk_pop, stk_wdata}, 0);
        @(posedge clk); #1;
        chk("t6_no_push", s_cnt, 0);
        chk("t6_no_ack", {ack0, ack1}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(0, 1'b1, 2'b10, e, rd, lat);
        chk("t6_restart_lat", lat, 3);
        chk("t6_restart_err", e, 0);
        chk("t6_depth", s_cnt, 1);

        // Random phase: push bias swings so the stack fills, drains and errors both ways.
        do_reset(1'b1);
        for (int seg = 0; seg < 12; seg++) begin
            automatic int bias = (seg % 3 == 0) ? 85 : ((seg % 3 == 1) ? 15 : 50);
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #1;
                req0   = ($urandom_range(0, 3) != 0);
                req1   = ($urandom_range(0, 3) != 0);
                op0    = ($urandom_range(0, 99) < bias);
                op1    = ($urandom_range(0, 99) < bias);
                wdata0 = 2'($urandom_range(0, 3));
                wdata1 = 2'($urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
